// File: rtl/btn_arbiter.sv
// Round-robin arbiter: latches shaper pulses as pending requests and offers them one at a time on a valid/ready load port.
// Optional per-channel re-press holdoff is enabled with `define BTN_ARB_HOLDOFF_EN.
module btn_arbiter #(
  parameter int IDW     = 2,
  parameter int HOLDOFF = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [2**IDW-1:0]   pulse_in,
  input  logic                load_ready,
  output logic                load_valid,
  output logic [IDW-1:0]      load_id,
  output logic [2**IDW-1:0]   pending,
  output logic                overflow
);
  localparam int N = 2**IDW;

  if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
    $error("btn_arbiter: HOLDOFF must be 1..255");
  end

  typedef enum logic {IDLE, OFFER} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             grant;
  logic [N-1:0]     clr;
  logic [N-1:0]     acc;
  logic [N-1:0]     hold_blk;
  logic             sel_found;
  logic [IDW-1:0]   sel_id;

`ifdef BTN_ARB_HOLDOFF_EN
  logic [N-1:0][7:0] hold_q, hold_d;

  // Counter reloads on the granting handshake, then counts down to zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hold_blk[i] = |hold_q[i];
      hold_d[i]   = hold_blk[i] ? hold_q[i] - 8'd1 : 8'd0;
      if (clr[i]) hold_d[i] = 8'(HOLDOFF);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign hold_blk = '0;
`endif

  // First pending bit at or above ptr, wrapping.
  always_comb begin
    logic [IDW-1:0] idx;
    sel_found = 1'b0;
    sel_id    = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + IDW'(k);
      if (!sel_found && pend_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: if (sel_found) begin
        id_d    = sel_id;
        state_d = OFFER;
      end
      OFFER: if (load_ready) begin
        grant   = 1'b1;
        ptr_d   = id_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A set on the same edge as the clear wins; merges raise a single flag.
  always_comb begin
    clr = '0;
    if (grant) clr[id_q] = 1'b1;
    acc    = pulse_in & ~hold_blk;
    pend_d = (pend_q & ~clr) | acc;
    ovf_d  = |(acc & pend_q & ~clr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign load_valid = (state_q == OFFER);
  assign load_id    = id_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;
endmodule

// File: doc/btn_arbiter.md
# btn_arbiter

Round-robin arbiter that shares one downstream load port between several button channels. Each channel input is the one-cycle shaped pulse produced by a `bshaper` instance. The block latches each pulse as a pending request and offers the requests one at a time on a valid/ready load interface. It sits between the bank of button shapers and the single consumer of load commands, such as the access/password controller.

## Interface
- `IDW`, default 2: channel-ID width; the number of channels is N = 2**IDW.
- `HOLDOFF`, default 8: holdoff length in cycles, 1..255. Used only when `BTN_ARB_HOLDOFF_EN` is defined.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous reset, active-high.
- `pulse_in`  in  N  one-cycle request pulses from the shapers, one bit per channel.
- `load_ready`  in  1  consumer accepts the offered request.
- `load_valid`  out  1  a request is being offered.
- `load_id`  out  IDW  channel number of the offered request.
- `pending`  out  N  registered pending-request flags.
- `overflow`  out  1  one-cycle flag: a request was merged into one already pending.

## Operation
- Pending set: `pulse_in[i]`=1 sampled at an edge sets `pending[i]`.
- Pending clear: `pending[i]` clears on the edge where `load_valid & load_ready` is true and `load_id`=i.
- Simultaneous set and clear on the same channel: the set wins, so the bit stays 1.
- Overflow: `pulse_in[i]`=1 while `pending[i]`=1 and that bit is not being cleared on this edge.
  - `overflow` is 1 for the following cycle.
  - The request is merged; there is no count.
  - Overflow from several channels on the same edge gives a single flag.
- FSM has two states:
  - IDLE: `load_valid`=0. If any `pending` bit is 1, select the first set bit searching upward from `ptr`, wrapping from N-1 to 0. Register it into `load_id` and go to OFFER.
  - OFFER: `load_valid`=1. `load_id` is held stable until a handshake. On `load_ready`=1, clear the granted pending bit, set `ptr` = `load_id`+1 mod N, and return to IDLE.
  - In OFFER, `load_ready`=0 holds indefinitely. New pulses only update `pending`; the offer is never re-arbitrated.
- `ptr` is an IDW-bit register and wraps naturally. Reset value is 0, so channel 0 has first priority after reset.
- `load_ready` is ignored in IDLE.

## Timing
- Reset values, asynchronous: `load_valid`=0, `load_id`=0, `pending`=0, `overflow`=0, `ptr`=0, FSM=IDLE, holdoff counters=0.
- Reset mid-offer:
  - `load_valid` drops immediately and the offer is lost.
  - All pending requests are discarded.
  - Requests arriving after reset release are handled normally.
- Latency: a pulse sampled at edge t sets `pending` after t. `load_valid` rises after edge t+1, assuming the FSM is idle with no other pending request.
- Handshake completes on the edge where `load_valid` & `load_ready` are both 1. `load_valid` is 0 for at least one cycle afterwards.
- Maximum throughput is one grant per 2 cycles. The consumer holding `load_ready`=1 permanently is legal.
- `pending` reflects the register state; it is not a combinational bypass of `pulse_in`.

## Configuration
- Macro `BTN_ARB_HOLDOFF_EN`.
- Defined:
  - Each channel has an 8-bit holdoff counter, loaded with `HOLDOFF` on the handshake that grants that channel.
  - The counter decrements each cycle while nonzero.
  - While the counter is nonzero, `pulse_in[i]` is dropped: it does not set `pending[i]` and does not raise `overflow`.
  - This suppresses repeat presses/bounce that get past the shaper.
- Undefined: no counters, every pulse is accepted, and `HOLDOFF` is unused.

## Test plan
- Reset/single request (N=4): after `RST` goes 1→0, pulse `pulse_in`=4'b0100 for one cycle with `load_ready`=1.
  - `load_valid` rises 2 edges after the pulse, with `load_id`=2.
  - `pending`=0 after the handshake; `ptr`=3.
- Round-robin: pulse 4'b1111 in one cycle, `load_ready`=1.
  - Grants come out in order 0,1,2,3, one every 2 cycles.
  - Then pulse 4'b0011: next grant is 0, then 1.
- Stall and merge: pulse 4'b0001, hold `load_ready`=0 for 10 cycles, pulse bit 0 again during the stall.
  - `load_valid`=1 with `load_id`=0 held stable for the whole stall.
  - `overflow` pulses once.
  - Exactly one grant when `load_ready` goes to 1.
- Simultaneous set/clear: pulse `pulse_in[1]` on the same edge as the handshake for channel 1.
  - `pending[1]` stays 1, `overflow`=0, and a second grant for channel 1 follows.
- Reset mid-offer: assert `RST` while `load_valid`=1 with 4'b1010 pending.
  - Outputs go to 0 immediately; no grant after release until new pulses arrive.
- Holdoff (macro defined, `HOLDOFF`=8): grant channel 3, then pulse channel 3 at 3 and at 9 cycles after the handshake.
  - The first pulse is dropped with `overflow`=0.
  - The second pulse is granted.
  - With the macro undefined, both pulses are accepted: the first is granted, and the second is either granted again or merged (with `overflow`) if the first is still pending.
